// File: rtl/cb_agd_sched.sv
// cb_agd_sched: two-requester scheduler in front of the covariance-block AGD.
// Grants one burst (row, start col, len), issues one (row, col) beat per cycle,
// and tracks the AGD pipeline latency with a {valid, tag, last} delay line.
// Optional macro CB_SCHED_PRIO_EN: fixed priority (requester 1 wins), no RR pointer.
module cb_agd_sched #(
  parameter int unsigned ROW_LEN      = 10,
  parameter int unsigned CB_AW        = 17,
  parameter int unsigned MAX_LANDMARK = 500,
  parameter int unsigned LEN_W        = 4,
  parameter int unsigned AGD_LAT      = 5
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [ROW_LEN-1:0] req_row0,
  input  logic [ROW_LEN-1:0] req_row1,
  input  logic [ROW_LEN-1:0] req_col0,
  input  logic [ROW_LEN-1:0] req_col1,
  input  logic [LEN_W-1:0]   req_len0,
  input  logic [LEN_W-1:0]   req_len1,
  output logic [ROW_LEN-1:0] agd_row,
  output logic [ROW_LEN-1:0] agd_col,
  input  logic [CB_AW-1:0]   agd_addr,
  output logic               out_valid,
  output logic [CB_AW-1:0]   out_addr,
  output logic               out_tag,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned DIM = 2 * MAX_LANDMARK + 3;
  // One extra bit so start col + beat index and the clip test never overflow.
  localparam int unsigned CW  = ROW_LEN + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ROW_LEN-1:0] row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic               tag_q, tag_d;
  logic [1:0]         ready_d;
  logic [ROW_LEN-1:0] agd_row_d, agd_col_d;
  logic               beat_v_q, beat_v_d;
  logic               beat_t_q, beat_t_d;
  logic               beat_l_q, beat_l_d;
  logic [AGD_LAT-1:0] dl_v, dl_t, dl_l;
  logic               busy_d;
  logic               gnt;
  logic [CW-1:0]      cur_col;
  logic [LEN_W-1:0]   req_len_g;
`ifndef CB_SCHED_PRIO_EN
  logic               rr_q, rr_d;
`endif

  // Arbitration: pick the requester to grant when in IDLE.
  always_comb begin
    gnt = 1'b0;
`ifdef CB_SCHED_PRIO_EN
    gnt = req_valid[1];
`else
    if (&req_valid) gnt = rr_q;
    else            gnt = req_valid[1];
`endif
  end

  // Next-state, burst expansion and beat issue.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    len_d     = len_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    ready_d   = 2'b00;
    agd_row_d = agd_row;
    agd_col_d = agd_col;
    beat_v_d  = 1'b0;
    beat_t_d  = 1'b0;
    beat_l_d  = 1'b0;
`ifndef CB_SCHED_PRIO_EN
    rr_d      = rr_q;
`endif
    cur_col   = col_q + CW'(idx_q);
    req_len_g = gnt ? req_len1 : req_len0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          ready_d = gnt ? 2'b10 : 2'b01;
          tag_d   = gnt;
          row_d   = gnt ? req_row1 : req_row0;
          col_d   = CW'(gnt ? req_col1 : req_col0);
          len_d   = (req_len_g == '0) ? LEN_W'(1) : req_len_g;
          idx_d   = '0;
          state_d = BURST;
`ifndef CB_SCHED_PRIO_EN
          rr_d    = ~gnt;
`endif
        end
      end
      BURST: begin
        if (cur_col < CW'(DIM)) begin
          agd_row_d = row_q;
          agd_col_d = cur_col[ROW_LEN-1:0];
          beat_v_d  = 1'b1;
          beat_t_d  = tag_q;
          beat_l_d  = (idx_q == len_q - LEN_W'(1)) || (cur_col + CW'(1) >= CW'(DIM));
          idx_d     = idx_q + LEN_W'(1);
          if (beat_l_d) state_d = IDLE;
        end else begin
          // Start column beyond the matrix: accept and drop the burst.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BURST) | beat_v_d | beat_v_q | (|dl_v[AGD_LAT-2:0]);
  end

  // State, capture registers, AGD drive and latency delay line.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tag_q     <= 1'b0;
      req_ready <= 2'b00;
      agd_row   <= '0;
      agd_col   <= '0;
      beat_v_q  <= 1'b0;
      beat_t_q  <= 1'b0;
      beat_l_q  <= 1'b0;
      dl_v      <= '0;
      dl_t      <= '0;
      dl_l      <= '0;
      busy      <= 1'b0;
`ifndef CB_SCHED_PRIO_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      req_ready <= ready_d;
      agd_row   <= agd_row_d;
      agd_col   <= agd_col_d;
      beat_v_q  <= beat_v_d;
      beat_t_q  <= beat_t_d;
      beat_l_q  <= beat_l_d;
      dl_v[0]   <= beat_v_q;
      dl_t[0]   <= beat_t_q;
      dl_l[0]   <= beat_l_q;
      for (int i = 1; i < int'(AGD_LAT); i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_t[i] <= dl_t[i-1];
        dl_l[i] <= dl_l[i-1];
      end
      busy      <= busy_d;
`ifndef CB_SCHED_PRIO_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // Delay-line head lines up with the AGD result for the same beat.
  assign out_valid = dl_v[AGD_LAT-1];
  assign out_tag   = dl_t[AGD_LAT-1];
  assign out_last  = dl_l[AGD_LAT-1];
  assign out_addr  = agd_addr;

endmodule
